clock_hms: RTL and testbench
============================

// Module: clock_hms
// PURPOSE
//  Parametrised HH:MM:SS wall clock: next generation of the board-level MM:SS clock.
//  Adds hours, a 12/24-hour mode with PM flag, a set-time FSM with digit blinking,
//  and a day-carry pulse. Top-level block driving six active-low 7-seg displays.
//  Inputs are already-debounced single-cycle pulses from the board button conditioner.
// PARAMETERS
//  CLK_FREQ  50_000_000  input clock cycles per second (>=2, even)
//  HOUR12    0           0: 00..23 hours; 1: 12..11 hours with PM flag
//  BLINK_EN  1           1: blank the digits being set during the blink-off half-second
// PORTS
//  CLK      in   1  system clock; all logic on rising edge
//  RST      in   1  synchronous, active-high reset
//  MODE     in   1  pulse: advance set-mode FSM
//  INC      in   1  pulse: increment the selected field (set states only)
//  CLR      in   1  pulse: clear time, return to RUN
//  SEC      out  7  {tens[2:0],units[3:0]} BCD seconds
//  MIN      out  7  {tens[2:0],units[3:0]} BCD minutes
//  HOUR     out  6  {tens[1:0],units[3:0]} BCD hours
//  PM       out  1  HOUR12=1: afternoon flag; tied 0 when HOUR12=0
//  DAY_CA   out  1  one-cycle pulse on the midnight roll-over
//  nHEX0..5 out  7  each: active-low segments gfedcba; 0,1=sec; 2,3=min; 4,5=hour
// BEHAVIOUR
//  Reset: state RUN, prescaler 0, SEC=MIN=0, HOUR=0 (HOUR12: 12, PM=0), DAY_CA=0,
//   blink phase = on (digits visible).
//  Prescaler: $clog2(CLK_FREQ)-bit counter 0..CLK_FREQ-1. tick = (cnt==CLK_FREQ-1).
//   half = (cnt==CLK_FREQ/2-1). The blink phase toggles on tick and on half.
//  FSM states: RUN, SET_H, SET_M. MODE: RUN->SET_H->SET_M->RUN.
//  RUN: each tick advances the time; the counters are registered, so the new time
//   is visible the cycle after tick.
//   Sec 59->00 carries into minutes; min 59->00 carries into hours (same cycle).
//   24h: 23:59:59 -> 00:00:00. 12h: 11:59:59 AM -> 12:00:00 PM (PM toggles);
//   12:59:59 -> 01:00:00 with PM unchanged; 11:59:59 PM -> 12:00:00 AM.
//   DAY_CA pulses for the one cycle after the midnight roll-over (24h 23->00; 12h PM->AM).
//  SET_H / SET_M: the prescaler is held at 0 and the time does not advance.
//   INC adds +1 to the selected field with wrap-around and no carry.
//   Hours: 24h 23->00; 12h 11->12 toggles PM, 12->01.
//   Minutes: 59->00. INC in RUN is ignored.
//  Leaving SET_M -> RUN: SEC cleared to 00 and the prescaler restarts at 0, so the
//   first tick follows CLK_FREQ cycles later.
//  Blink: with BLINK_EN=1 and blink phase off, nHEX5/4 are 7'h7F in SET_H and nHEX3/2
//   are 7'h7F in SET_M. The BCD outputs are never blanked. In RUN, all digits are shown.
//  Priority when pulses coincide in one cycle: RST > CLR > MODE > INC > tick.
//   Lower-priority events in that cycle are dropped (a coincident tick is lost).
//  CLR: time set to the reset value, state -> RUN, prescaler -> 0; DAY_CA is not pulsed.
//  Tens digits display blank-free (leading 0 shown). Display decode is combinational
//   from the registered BCD values.
// STRUCTURE
//  Shared package clock_pkg: state enum {RUN,SET_H,SET_M}, SEG_BLANK=7'h7F, BCD->7-seg
//   function (active-low, digits 0-9; other codes blank).
//  Sub-module cnt_mod_bcd #(MOD): two-digit BCD counter with CEN, INC, CLR and a CA
//   carry pulse on MOD-1 -> 0. It is instantiated for sec (60) and min (60).
//  Hours are handled locally (12/24 and PM logic). The FSM, prescaler, blink and
//   display muxing live in the top.
// TESTING (CLK_FREQ=4 unless noted)
//  Reset -> SEC=MIN=HOUR=0, DAY_CA=0, nHEX0..5=7'h40 ("0"); HOUR12=1: HOUR=6'h12, PM=0.
//  Preload 23:59:58 via SET states, run 8 cycles -> 23:59:59 then 00:00:00; DAY_CA high 1 cycle.
//  HOUR12=1: 11:59:59 AM +tick -> 12:00:00 PM=1; 12:59:59 PM +tick -> 01:00:00 PM=1.
//  MODE, then INC x25 in SET_H (24h) -> HOUR=01, MIN unchanged; 4 idle ticks -> time frozen.
//  In SET_M, nHEX3/2 = 7'h7F for 2 cycles then visible for 2; MODE -> RUN, SEC=00, ticks resume.
//  CLR+MODE+INC in the same cycle as tick -> time 00:00:00, state RUN, no advance that cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the HH:MM:SS wall clock.
//  - state_t      : set-mode FSM states (RUN, SET_H, SET_M)
//  - SEG_BLANK    : active-low pattern with every segment off
//  - bcd_to_seg   : BCD digit -> active-low gfedcba segments (0-9, others blank)
//  - hour_step    : one-hour increment with 12/24-hour wrap and PM handling
// ---------------------------------------------------------------------------
package clock_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low segment patterns, bit order gfedcba.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
      logic [6:0] seg;
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Returns {pm_next, hour_next}. In 12-hour mode the clock face runs
   // 12,01..11, so 11->12 is where AM/PM flips and 12->01 keeps the flag.
   function automatic logic [6:0] hour_step(input logic [5:0] hour,
                                             input logic       pm,
                                             input logic       hour12);
      logic [5:0] hour_next;
      logic       pm_next;
      hour_next = hour;
      pm_next   = pm;
      if (hour12 && hour == 6'h11) begin
         hour_next = 6'h12;
         pm_next   = ~pm;
      end else if (hour12 && hour == 6'h12) begin
         hour_next = 6'h01;
      end else if (!hour12 && hour == 6'h23) begin
         hour_next = 6'h00;
      end else if (hour[3:0] == 4'd9) begin
         hour_next = {hour[5:4] + 2'd1, 4'd0};
      end else begin
         hour_next = {hour[5:4], hour[3:0] + 4'd1};
      end
      return {pm_next, hour_next};
   endfunction

endpackage

// File: rtl/cnt_mod_bcd.sv
// ---------------------------------------------------------------------------
// cnt_mod_bcd
// Two-digit BCD counter that wraps from MOD-1 to 0.
// Ports:
//  clk   in   1  clock, rising edge
//  rst   in   1  synchronous active-high reset
//  cen   in   1  count enable (time advance)
//  inc   in   1  manual increment (same step as cen, used in set mode)
//  clr   in   1  synchronous clear, highest priority after rst
//  value out  7  {tens[2:0], units[3:0]}
//  ca    out  1  combinational carry: cen is stepping the counter out of MOD-1
// ---------------------------------------------------------------------------
module cnt_mod_bcd #(
   parameter int MOD = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       inc,
   input  logic       clr,
   output logic [6:0] value,
   output logic       ca
);

   localparam logic [2:0] LAST_TENS  = 3'((MOD - 1) / 10);
   localparam logic [3:0] LAST_UNITS = 4'((MOD - 1) % 10);

   logic [2:0] tens;
   logic [3:0] units;
   logic       at_last;

   assign at_last = (tens == LAST_TENS) && (units == LAST_UNITS);

   // The carry is combinational so the next counter in the chain steps in
   // the same clock edge. A manual increment never carries.
   assign ca    = cen && !inc && !clr && at_last;
   assign value = {tens, units};

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tens  <= 3'd0;
         units <= 4'd0;
      end else if (inc || cen) begin
         if (at_last) begin
            tens  <= 3'd0;
            units <= 4'd0;
         end else if (units == 4'd9) begin
            tens  <= tens + 3'd1;
            units <= 4'd0;
         end else begin
            units <= units + 4'd1;
         end
      end
   end

endmodule

// File: rtl/clock_hms.sv
// ---------------------------------------------------------------------------
// clock_hms
// HH:MM:SS wall clock with 12/24-hour mode, set-time FSM, digit blinking,
// day-carry pulse and six active-low 7-segment digit outputs.
// Ports:
//  CLK          in   1  system clock, rising edge
//  RST          in   1  synchronous active-high reset
//  MODE         in   1  pulse: RUN -> SET_H -> SET_M -> RUN
//  INC          in   1  pulse: increment selected field in set states
//  CLR          in   1  pulse: clear time, back to RUN
//  SEC          out  7  BCD seconds {tens[2:0],units[3:0]}
//  MIN          out  7  BCD minutes {tens[2:0],units[3:0]}
//  HOUR         out  6  BCD hours   {tens[1:0],units[3:0]}
//  PM           out  1  afternoon flag (12-hour mode only)
//  DAY_CA       out  1  one-cycle pulse after the midnight roll-over
//  nHEX0..nHEX5 out  7  active-low gfedcba; 0,1 sec; 2,3 min; 4,5 hour
// ---------------------------------------------------------------------------
module clock_hms
   import clock_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter bit HOUR12   = 1'b0,
   parameter bit BLINK_EN = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       MODE,
   input  logic       INC,
   input  logic       CLR,
   output logic [6:0] SEC,
   output logic [6:0] MIN,
   output logic [5:0] HOUR,
   output logic       PM,
   output logic       DAY_CA,
   output logic [6:0] nHEX0,
   output logic [6:0] nHEX1,
   output logic [6:0] nHEX2,
   output logic [6:0] nHEX3,
   output logic [6:0] nHEX4,
   output logic [6:0] nHEX5
);

   localparam int          CW        = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_FREQ - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_FREQ / 2 - 1);
   localparam logic [5:0]  HOUR_RST  = HOUR12 ? 6'h12 : 6'h00;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   presc;
   logic [CW-1:0]   blink_cnt;
   logic            blink_on;
   logic [5:0]      hour;
   logic            pm;
   logic            day_ca;

   logic            mode_evt;
   logic            inc_evt;
   logic            tick_evt;
   logic            sec_clr;
   logic            sec_ca;
   logic            min_ca;
   logic            min_inc;
   logic            hour_inc;
   logic            midnight;
   logic [6:0]      hour_next;

   // Pulse priority: CLR beats MODE beats INC beats tick. A tick is only
   // possible in RUN because the prescaler is parked at 0 in set states.
   assign mode_evt = MODE && !CLR;
   assign inc_evt  = INC && !CLR && !MODE;
   assign tick_evt = (state == RUN) && (presc == CNT_LAST) && !CLR && !MODE;

   assign min_inc  = inc_evt && (state == SET_M);
   assign hour_inc = inc_evt && (state == SET_H);

   // Seconds restart from 00 whenever the user finishes setting the time.
   assign sec_clr  = CLR || (mode_evt && (state == SET_M));

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: CLR always returns to RUN, MODE steps the cycle.
   always_comb begin
      state_next = state;
      if (CLR) begin
         state_next = RUN;
      end else if (MODE) begin
         case (state)
            RUN:     state_next = SET_H;
            SET_H:   state_next = SET_M;
            SET_M:   state_next = RUN;
            default: state_next = RUN;
         endcase
      end
   end

   // One-second prescaler. It only runs in RUN, and any CLR or MODE pulse
   // restarts it so the first tick after returning to RUN is a full second away.
   always_ff @(posedge CLK) begin
      if (RST) begin
         presc <= '0;
      end else if (CLR || MODE || state != RUN) begin
         presc <= '0;
      end else if (presc == CNT_LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Blink timebase. It keeps running in set states, where the prescaler is
   // parked. Entering a set state starts in the off phase so the selected
   // field visibly reacts to MODE; in RUN it stays aligned with the prescaler
   // and toggles on every tick and half-second.
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (mode_evt) begin
         blink_cnt <= '0;
         blink_on  <= (state_next == RUN);
      end else begin
         if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         if (blink_cnt == CNT_LAST || blink_cnt == CNT_HALF) begin
            blink_on <= ~blink_on;
         end
      end
   end

   cnt_mod_bcd #(.MOD(60)) u_sec (
      .clk   (CLK),
      .rst   (RST),
      .cen   (tick_evt),
      .inc   (1'b0),
      .clr   (sec_clr),
      .value (SEC),
      .ca    (sec_ca)
   );

   cnt_mod_bcd #(.MOD(60)) u_min (
      .clk   (CLK),
      .rst   (RST),
      .cen   (sec_ca),
      .inc   (min_inc),
      .clr   (CLR),
      .value (MIN),
      .ca    (min_ca)
   );

   assign hour_next = hour_step(hour, pm, HOUR12);
   assign midnight  = HOUR12 ? (hour == 6'h11 && pm) : (hour == 6'h23);

   // Hours and PM flag. Only a tick-driven roll-over past midnight raises
   // DAY_CA; setting the hour by hand or clearing never does.
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         hour   <= HOUR_RST;
         pm     <= 1'b0;
         day_ca <= 1'b0;
      end else begin
         day_ca <= min_ca && midnight;
         if (hour_inc || min_ca) begin
            hour <= hour_next[5:0];
            pm   <= hour_next[6];
         end
      end
   end

   assign HOUR   = hour;
   assign PM     = HOUR12 ? pm : 1'b0;
   assign DAY_CA = day_ca;

   // Display decode from the registered BCD values. Only the field being
   // set is blanked, and only during the off half of the blink period.
   always_comb begin
      nHEX0 = bcd_to_seg(SEC[3:0]);
      nHEX1 = bcd_to_seg({1'b0, SEC[6:4]});
      nHEX2 = bcd_to_seg(MIN[3:0]);
      nHEX3 = bcd_to_seg({1'b0, MIN[6:4]});
      nHEX4 = bcd_to_seg(hour[3:0]);
      nHEX5 = bcd_to_seg({2'b00, hour[5:4]});
      if (BLINK_EN && !blink_on) begin
         if (state == SET_H) begin
            nHEX4 = SEG_BLANK;
            nHEX5 = SEG_BLANK;
         end else if (state == SET_M) begin
            nHEX2 = SEG_BLANK;
            nHEX3 = SEG_BLANK;
         end
      end
   end

endmodule

// File: tb/tb_clock_hms.sv
// ---------------------------------------------------------------------------
// tb_clock_hms
// Directed bench for clock_hms with CLK_FREQ=4. One instance runs in 24-hour
// mode and one in 12-hour mode; both share the clock and reset.
// ---------------------------------------------------------------------------
module tb_clock_hms;

   logic       clk;
   logic       rst;
   logic       mode24, inc24, clr24;
   logic       mode12, inc12, clr12;
   logic [6:0] sec24, min24, sec12, min12;
   logic [5:0] hour24, hour12;
   logic       pm24, pm12, day24, day12;
   logic [6:0] hex24 [6];
   logic [6:0] hex12 [6];

   int n_checks;
   int n_errors;

   clock_hms #(.CLK_FREQ(4), .HOUR12(1'b0), .BLINK_EN(1'b1)) dut24 (
      .CLK(clk), .RST(rst), .MODE(mode24), .INC(inc24), .CLR(clr24),
      .SEC(sec24), .MIN(min24), .HOUR(hour24), .PM(pm24), .DAY_CA(day24),
      .nHEX0(hex24[0]), .nHEX1(hex24[1]), .nHEX2(hex24[2]),
      .nHEX3(hex24[3]), .nHEX4(hex24[4]), .nHEX5(hex24[5])
   );

   clock_hms #(.CLK_FREQ(4), .HOUR12(1'b1), .BLINK_EN(1'b1)) dut12 (
      .CLK(clk), .RST(rst), .MODE(mode12), .INC(inc12), .CLR(clr12),
      .SEC(sec12), .MIN(min12), .HOUR(hour12), .PM(pm12), .DAY_CA(day12),
      .nHEX0(hex12[0]), .nHEX1(hex12[1]), .nHEX2(hex12[2]),
      .nHEX3(hex12[3]), .nHEX4(hex12[4]), .nHEX5(hex12[5])
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; inputs change and outputs are sampled 1 unit later.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic pulse24(input logic m, input logic i, input logic c);
      mode24 = m; inc24 = i; clr24 = c;
      cycle();
      mode24 = 1'b0; inc24 = 1'b0; clr24 = 1'b0;
   endtask

   task automatic pulse12(input logic m, input logic i, input logic c);
      mode12 = m; inc12 = i; clr12 = c;
      cycle();
      mode12 = 1'b0; inc12 = 1'b0; clr12 = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run(2);
      rst = 1'b0;
   endtask

   // Reset values of both instances and the "0"/"12" display patterns.
   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({hour24, min24, sec24} !== {6'h00, 7'h00, 7'h00}) begin
         n_errors++;
         $display("[TB] FAIL reset_time24: got %h expected %h", {hour24, min24, sec24}, 20'h0);
      end
      n_checks++;
      if (day24 !== 1'b0 || pm24 !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_flags24: got day=%b pm=%b expected 0 0", day24, pm24);
      end
      n_checks++;
      if ({hex24[5], hex24[4], hex24[3], hex24[2], hex24[1], hex24[0]} !== {6{7'h40}}) begin
         n_errors++;
         $display("[TB] FAIL reset_hex24: got %h %h %h %h %h %h expected all 40",
                  hex24[5], hex24[4], hex24[3], hex24[2], hex24[1], hex24[0]);
      end
      n_checks++;
      if ({pm12, hour12, min12, sec12} !== {1'b0, 6'h12, 7'h00, 7'h00}) begin
         n_errors++;
         $display("[TB] FAIL reset_time12: got pm=%b %h:%h:%h expected 0 12:00:00",
                  pm12, hour12, min12, sec12);
      end
      n_checks++;
      if ({hex12[5], hex12[4]} !== {7'h79, 7'h24}) begin
         n_errors++;
         $display("[TB] FAIL reset_hex12: got %h %h expected 79 24", hex12[5], hex12[4]);
      end
   endtask

   // Preload 23:59 via the set states, count to 23:59:58, then roll over.
   task automatic test_day_rollover();
      do_reset();
      pulse24(1, 0, 0);
      repeat (23) pulse24(0, 1, 0);
      n_checks++;
      if (hour24 !== 6'h23) begin
         n_errors++;
         $display("[TB] FAIL set_hour23: got %h expected 23", hour24);
      end
      pulse24(1, 0, 0);
      repeat (59) pulse24(0, 1, 0);
      pulse24(1, 0, 0);
      n_checks++;
      if ({hour24, min24, sec24} !== {6'h23, 7'h59, 7'h00}) begin
         n_errors++;
         $display("[TB] FAIL preload: got %h:%h:%h expected 23:59:00", hour24, min24, sec24);
      end
      run(232);
      n_checks++;
      if ({hour24, min24, sec24} !== {6'h23, 7'h59, 7'h58}) begin
         n_errors++;
         $display("[TB] FAIL at_235958: got %h:%h:%h expected 23:59:58", hour24, min24, sec24);
      end
      run(4);
      n_checks++;
      if ({hour24, min24, sec24, day24} !== {6'h23, 7'h59, 7'h59, 1'b0}) begin
         n_errors++;
         $display("[TB] FAIL at_235959: got %h:%h:%h day=%b expected 23:59:59 day=0",
                  hour24, min24, sec24, day24);
      end
      run(4);
      n_checks++;
      if ({hour24, min24, sec24, day24} !== {6'h00, 7'h00, 7'h00, 1'b1}) begin
         n_errors++;
         $display("[TB] FAIL midnight24: got %h:%h:%h day=%b expected 00:00:00 day=1",
                  hour24, min24, sec24, day24);
      end
      run(1);
      n_checks++;
      if (day24 !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL day_pulse_width: got %b expected 0", day24);
      end
   endtask

   // 12-hour mode: AM->PM at noon, 12->01 keeps PM, PM->AM at midnight.
   task automatic test_hour12();
      do_reset();
      pulse12(1, 0, 0);
      repeat (11) pulse12(0, 1, 0);
      n_checks++;
      if ({pm12, hour12} !== {1'b0, 6'h11}) begin
         n_errors++;
         $display("[TB] FAIL set12_hour11: got pm=%b %h expected 0 11", pm12, hour12);
      end
      pulse12(1, 0, 0);
      repeat (59) pulse12(0, 1, 0);
      pulse12(1, 0, 0);
      run(236);
      n_checks++;
      if ({pm12, hour12, min12, sec12} !== {1'b0, 6'h11, 7'h59, 7'h59}) begin
         n_errors++;
         $display("[TB] FAIL am_115959: got pm=%b %h:%h:%h expected 0 11:59:59",
                  pm12, hour12, min12, sec12);
      end
      run(4);
      n_checks++;
      if ({pm12, hour12, min12, sec12, day12} !== {1'b1, 6'h12, 7'h00, 7'h00, 1'b0}) begin
         n_errors++;
         $display("[TB] FAIL noon: got pm=%b %h:%h:%h day=%b expected 1 12:00:00 day=0",
                  pm12, hour12, min12, sec12, day12);
      end
      pulse12(1, 0, 0);
      pulse12(1, 0, 0);
      repeat (59) pulse12(0, 1, 0);
      pulse12(1, 0, 0);
      run(236);
      run(4);
      n_checks++;
      if ({pm12, hour12, min12, sec12} !== {1'b1, 6'h01, 7'h00, 7'h00}) begin
         n_errors++;
         $display("[TB] FAIL pm_1259_roll: got pm=%b %h:%h:%h expected 1 01:00:00",
                  pm12, hour12, min12, sec12);
      end
      pulse12(1, 0, 0);
      repeat (10) pulse12(0, 1, 0);
      n_checks++;
      if ({pm12, hour12} !== {1'b1, 6'h11}) begin
         n_errors++;
         $display("[TB] FAIL set12_pm11: got pm=%b %h expected 1 11", pm12, hour12);
      end
      pulse12(1, 0, 0);
      repeat (59) pulse12(0, 1, 0);
      pulse12(1, 0, 0);
      run(240);
      n_checks++;
      if ({pm12, hour12, min12, sec12, day12} !== {1'b0, 6'h12, 7'h00, 7'h00, 1'b1}) begin
         n_errors++;
         $display("[TB] FAIL midnight12: got pm=%b %h:%h:%h day=%b expected 0 12:00:00 day=1",
                  pm12, hour12, min12, sec12, day12);
      end
   endtask

   // Hour wrap while setting, frozen time in set mode, INC ignored in RUN.
   task automatic test_set_hours();
      do_reset();
      run(8);
      pulse24(1, 0, 0);
      repeat (25) pulse24(0, 1, 0);
      n_checks++;
      if ({hour24, min24, sec24} !== {6'h01, 7'h00, 7'h02}) begin
         n_errors++;
         $display("[TB] FAIL inc_x25: got %h:%h:%h expected 01:00:02", hour24, min24, sec24);
      end
      run(16);
      n_checks++;
      if ({hour24, min24, sec24} !== {6'h01, 7'h00, 7'h02}) begin
         n_errors++;
         $display("[TB] FAIL frozen: got %h:%h:%h expected 01:00:02", hour24, min24, sec24);
      end
      pulse24(1, 0, 0);
      pulse24(1, 0, 0);
      pulse24(0, 1, 0);
      n_checks++;
      if ({hour24, min24, sec24} !== {6'h01, 7'h00, 7'h00}) begin
         n_errors++;
         $display("[TB] FAIL inc_in_run: got %h:%h:%h expected 01:00:00", hour24, min24, sec24);
      end
   endtask

   // Blink pattern of the field being set, then clean return to RUN.
   task automatic test_blink();
      do_reset();
      run(4);
      pulse24(1, 0, 0);
      n_checks++;
      if ({hex24[5], hex24[4], hex24[3], hex24[2]} !== {7'h7F, 7'h7F, 7'h40, 7'h40}) begin
         n_errors++;
         $display("[TB] FAIL blink_seth: got %h %h %h %h expected 7f 7f 40 40",
                  hex24[5], hex24[4], hex24[3], hex24[2]);
      end
      pulse24(1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if ({hex24[3], hex24[2], hex24[4], min24} !==
             ((k == 2 || k == 3) ? {7'h40, 7'h40, 7'h40, 7'h00} : {7'h7F, 7'h7F, 7'h40, 7'h00})) begin
            n_errors++;
            $display("[TB] FAIL blink_setm_%0d: got %h %h hex4=%h min=%h", k,
                     hex24[3], hex24[2], hex24[4], min24);
         end
         if (k < 4) cycle();
      end
      pulse24(1, 0, 0);
      n_checks++;
      if ({sec24, hex24[3], hex24[2]} !== {7'h00, 7'h40, 7'h40}) begin
         n_errors++;
         $display("[TB] FAIL exit_setm: got sec=%h hex=%h %h expected 00 40 40",
                  sec24, hex24[3], hex24[2]);
      end
      run(3);
      n_checks++;
      if (sec24 !== 7'h00) begin
         n_errors++;
         $display("[TB] FAIL first_tick_early: got %h expected 00", sec24);
      end
      run(1);
      n_checks++;
      if (sec24 !== 7'h01) begin
         n_errors++;
         $display("[TB] FAIL first_tick: got %h expected 01", sec24);
      end
   endtask

   // Coincident pulses: CLR wins over MODE/INC/tick; MODE wins over INC.
   task automatic test_priority();
      do_reset();
      pulse24(1, 0, 0);
      repeat (5) pulse24(0, 1, 0);
      pulse24(1, 1, 0);
      n_checks++;
      if ({hour24, min24} !== {6'h05, 7'h00}) begin
         n_errors++;
         $display("[TB] FAIL mode_over_inc: got %h:%h expected 05:00", hour24, min24);
      end
      pulse24(1, 0, 0);
      run(7);
      n_checks++;
      if ({hour24, min24, sec24} !== {6'h05, 7'h00, 7'h01}) begin
         n_errors++;
         $display("[TB] FAIL pre_clr: got %h:%h:%h expected 05:00:01", hour24, min24, sec24);
      end
      pulse24(1, 1, 1);
      n_checks++;
      if ({hour24, min24, sec24, day24} !== {6'h00, 7'h00, 7'h00, 1'b0}) begin
         n_errors++;
         $display("[TB] FAIL clr_all: got %h:%h:%h day=%b expected 00:00:00 day=0",
                  hour24, min24, sec24, day24);
      end
      run(3);
      n_checks++;
      if (sec24 !== 7'h00) begin
         n_errors++;
         $display("[TB] FAIL clr_presc: got %h expected 00", sec24);
      end
      run(1);
      n_checks++;
      if ({sec24, hex24[5], hex24[4]} !== {7'h01, 7'h40, 7'h40}) begin
         n_errors++;
         $display("[TB] FAIL clr_run: got sec=%h hex=%h %h expected 01 40 40",
                  sec24, hex24[5], hex24[4]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      mode24 = 1'b0; inc24 = 1'b0; clr24 = 1'b0;
      mode12 = 1'b0; inc12 = 1'b0; clr12 = 1'b0;
      test_reset();
      test_day_rollover();
      test_hour12();
      test_set_hours();
      test_blink();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
